// File: rtl/plru_pkg.sv
// rtl/plru_pkg.sv - shared FSM state type and default geometry for the tree-PLRU replacer
package plru_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_FLUSH
    } state_t;

    localparam int DEF_WAYS  = 8;
    localparam int DEF_SETS  = 64;
    localparam int DEF_WAY_W = $clog2(DEF_WAYS);
    localparam int DEF_SET_W = $clog2(DEF_SETS);

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - combinational tree-PLRU walk: picks the used way and flips its path bits away from it
module plru_tree
    import plru_pkg::*;
#(
    parameter  int WAYS  = DEF_WAYS,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  bits,
    input  logic             hit,
    input  logic [WAY_W-1:0] way,
    output logic [WAY_W-1:0] sel_way,
    output logic [WAYS-2:0]  next_bits
);

    logic [WAY_W-1:0] node;
    logic             dir;

    // Heap walk, MSB of the way index first; a hit steers by its own way bits.
    always_comb begin
        next_bits = bits;
        sel_way   = '0;
        node      = '0;
        dir       = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir                  = hit ? way[WAY_W-1-l] : bits[node];
            next_bits[node]      = ~dir;
            sel_way[WAY_W-1-l]   = dir;
            node                 = (node << 1) + WAY_W'(dir) + WAY_W'(1);
        end
    end

endmodule

// File: rtl/plru_replacer.sv
// rtl/plru_replacer.sv - per-set tree-PLRU victim selection with flush sweep; PLRU_REPLACER_STATS_EN adds hit/miss counters
module plru_replacer
    import plru_pkg::*;
#(
    parameter  int WAYS  = DEF_WAYS,
    parameter  int SETS  = DEF_SETS,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic             req_hit,
    input  logic [WAY_W-1:0] req_way,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_hit,
`ifdef PLRU_REPLACER_STATS_EN
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
`endif
    output logic             busy
);

    state_t                       state;
    state_t                       state_nxt;
    logic [SETS-1:0][WAYS-2:0]    plru;
    logic [SET_W-1:0]             flush_idx;
    logic                         flush_pend;
    logic                         flush_eff;
    logic                         flush_take;
    logic                         accept;
    logic [WAY_W-1:0]             sel_way;
    logic [WAYS-2:0]              next_bits;

    plru_tree #(.WAYS(WAYS)) u_tree (
        .bits      (plru[req_set]),
        .hit       (req_hit),
        .way       (req_way),
        .sel_way   (sel_way),
        .next_bits (next_bits)
    );

    // A flush seen while the response was stalled counts as if it were still asserted.
    assign flush_eff = flush | flush_pend;
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state == ST_FLUSH);

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        flush_take = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = ~flush_eff;
                if (flush_eff) begin
                    flush_take = 1'b1;
                    state_nxt  = ST_FLUSH;
                end else if (req_valid) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    req_ready = ~flush_eff;
                    if (flush_eff) begin
                        flush_take = 1'b1;
                        state_nxt  = ST_FLUSH;
                    end else if (req_valid) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_idx == SET_W'(SETS-1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            plru       <= '0;
            flush_idx  <= '0;
            flush_pend <= 1'b0;
            rsp_way    <= '0;
            rsp_hit    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush_take)
                flush_pend <= 1'b0;
            else if (state == ST_RESP && flush && !rsp_ready)
                flush_pend <= 1'b1;
            if (flush_take)
                flush_idx <= '0;
            else if (state == ST_FLUSH)
                flush_idx <= flush_idx + 1'b1;
            if (accept) begin
                rsp_way       <= sel_way;
                rsp_hit       <= req_hit;
                plru[req_set] <= next_bits;
            end
            if (state == ST_FLUSH)
                plru[flush_idx] <= '0;
        end
    end

`ifdef PLRU_REPLACER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (flush_take) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (req_hit && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (!req_hit && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/plru_replacer.md
PLRU_REPLACER -- requirements
Module: plru_replacer

Interface
REQ-001 Parameter WAYS, default 8, associativity; power of two, 2..16.
REQ-002 Parameter SETS, default 64, number of sets; power of two.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  lookup result offered.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 req_set  input  $clog2(SETS)  set index of access.
REQ-008 req_hit  input  1  1 = tag hit, 0 = miss.
REQ-009 req_way  input  $clog2(WAYS)  encoded hit way from the way encoder; ignored when req_hit=0.
REQ-010 flush  input  1  pulse; request to clear all replacement state.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  consumer takes response.
REQ-013 rsp_way  output  $clog2(WAYS)  way used: hit way on hit, chosen victim on miss.
REQ-014 rsp_hit  output  1  copy of accepted req_hit.
REQ-015 busy  output  1  high while flush sweep in progress.

Function
REQ-016 Tree PLRU per set: WAYS-1 bits, heap order (node 0 root; node n children 2n+1, 2n+2); bit 1 = victim in upper half.
REQ-017 Miss victim: walk from root following bits; leaf reached is rsp_way.
REQ-018 On every accepted request, the bits on the path to the used way (hit way or victim) SHALL be set to point away from it; all other bits unchanged.
REQ-019 Handshake: request accepted when req_valid && req_ready; response transferred when rsp_valid && rsp_ready.
REQ-020 States IDLE, RESP, FLUSH; IDLE->RESP on accept; RESP->RESP on response taken with new accept; RESP->IDLE on response taken with no accept; RESP holds while rsp_ready=0.
REQ-021 Latency: request accepted at edge N gives rsp_valid=1 after edge N; state write completes at edge N.
REQ-022 req_ready = (state==IDLE && !flush) || (state==RESP && rsp_ready && !flush); full throughput of one request per cycle.
REQ-023 Back-to-back requests to the same set SHALL see the update of the previous request (no stale read).
REQ-024 rsp_way, rsp_hit SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-025 flush is taken in IDLE, or in RESP on the cycle the response is taken; flush wins over a simultaneous req_valid (request not accepted).
REQ-026 A flush arriving in RESP with rsp_ready=0 SHALL be held pending and taken on the response-handshake cycle.
REQ-027 FLUSH clears one set per cycle, index 0..SETS-1, SETS cycles, busy=1, req_ready=0, then IDLE.
REQ-028 flush asserted during FLUSH is ignored.

Reset
REQ-029 rst asserted: state IDLE, all PLRU bits 0, rsp_valid=0, rsp_way=0, rsp_hit=0, busy=0, flush counter 0, pending flush cleared.
REQ-030 rst mid-flush or mid-response SHALL abort immediately; first accept possible on the first edge after rst deasserts.

Configuration
REQ-031 Macro PLRU_REPLACER_STATS_EN defined: outputs hit_count and miss_count (32-bit each), reset to 0, incremented on each accepted hit/miss, saturating at all-ones, cleared by flush.
REQ-032 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-033 Package plru_pkg holds the state enum, default WAYS/SETS constants, and the index-width localparams.
REQ-034 One combinational sub-module plru_tree: inputs bits + hit + way, outputs selected way + next bits; instantiated once.

Verification
REQ-035 Reset, then miss on set 3 -> rsp_way=0 next cycle; second miss on set 3 -> rsp_way=4; third miss -> rsp_way=2 (WAYS=8).
REQ-036 Hit way 0 then hit way 4 on set 5, then miss on set 5 -> rsp_way=2; misses on set 6 still return 0.
REQ-037 Hold rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready=0, rsp_way stable, one response only per accept.
REQ-038 Update set 7, pulse flush -> busy=1 for SETS=64 cycles, req_ready=0; then miss on set 7 -> rsp_way=0.
REQ-039 flush and req_valid same cycle in IDLE -> flush taken, request not accepted; rst mid-flush -> busy=0 next cycle.
REQ-040 With PLRU_REPLACER_STATS_EN: 3 hits, 2 misses -> hit_count=3, miss_count=2; flush -> both 0.
